// File: rtl/me_stage_hs_pkg.sv
// me_stage_hs shared types: access sizes, slot FSM states, alignment helper.
// Used by every me_stage_hs file via import me_stage_hs_pkg::*.
package me_stage_hs_pkg;

   localparam int XLEN_DEF = 32;

   localparam logic [1:0] SZ_B = 2'd0;
   localparam logic [1:0] SZ_H = 2'd1;
   localparam logic [1:0] SZ_W = 2'd2;
   localparam logic [1:0] SZ_D = 2'd3;

   typedef enum logic {
      ST_IDLE   = 1'b0,
      ST_WAIT_R = 1'b1
   } me_state_e;

   function automatic logic misaligned(
      input logic [2:0] lo,
      input logic [1:0] sz
   );
      logic [3:0] m;
      m = (4'd1 << sz) - 4'd1;
      return |({1'b0, lo} & m);
   endfunction

endpackage

// File: rtl/me_stage_hs_if.sv
// Data RAM req/gnt/rvalid bus between the MEM stage (master) and RAM (slave).
interface me_stage_hs_if #(
   parameter int XLEN = 32,
   parameter int DAW  = 32
);
   localparam int NB = XLEN / 8;

   logic            dmem_req;
   logic            dmem_we;
   logic [NB-1:0]   dmem_be;
   logic [DAW-1:0]  dmem_addr;
   logic [XLEN-1:0] dmem_wdata;
   logic            dmem_gnt;
   logic            dmem_rvalid;
   logic [XLEN-1:0] dmem_rdata;

   modport master (
      output dmem_req, dmem_we, dmem_be,
      output dmem_addr, dmem_wdata,
      input  dmem_gnt, dmem_rvalid, dmem_rdata
   );

   modport slave (
      input  dmem_req, dmem_we, dmem_be,
      input  dmem_addr, dmem_wdata,
      output dmem_gnt, dmem_rvalid, dmem_rdata
   );

endinterface

// File: rtl/me_stage_hs_lane_ctrl.sv
// Byte-lane steering: store byte enables/data shift, load align and extend.
module me_lane_ctrl
   import me_stage_hs_pkg::*;
#(
   parameter  int XLEN = XLEN_DEF,
   localparam int NB   = XLEN / 8,
   localparam int OB   = $clog2(NB)
) (
   input  logic [OB-1:0]   off,
   input  logic [1:0]      size,
   input  logic            uns,
   input  logic [XLEN-1:0] st_data,
   input  logic [XLEN-1:0] rdata,
   output logic [NB-1:0]   be,
   output logic [XLEN-1:0] wdata,
   output logic [XLEN-1:0] ld_data
);

   logic [3:0]      nbytes;
   logic [15:0]     mask;
   logic [15:0]     be_w;
   logic [XLEN-1:0] sh;
   logic            sign;
   int              nbits;

   always_comb begin
      nbytes  = 4'd1 << size;
      mask    = (16'd1 << nbytes) - 16'd1;
      be_w    = mask << off;
      be      = be_w[NB-1:0];
      wdata   = st_data << {off, 3'b000};
      sh      = rdata >> {off, 3'b000};
      nbits   = 8 * int'(nbytes);
      // a D access on a 32-bit core degenerates to a full word
      if (nbits > XLEN) nbits = XLEN;
      sign    = sh[nbits-1] & ~uns;
      ld_data = '0;
      for (int i = 0; i < XLEN; i++)
         ld_data[i] = (i < nbits) ? sh[i] : sign;
   end

endmodule

// File: rtl/me_stage_hs.sv
// MEM stage: single-entry slot with valid/ready, data RAM via req/gnt/rvalid.
// Optional MISALIGN_TRAP_EN: misaligned accesses retire without a request.
module me_stage_hs
   import me_stage_hs_pkg::*;
#(
   parameter int XLEN                = XLEN_DEF,
   parameter int REG_FILE_ADDR_WIDTH = 5,
   parameter int DATA_ADDR_WIDTH     = 32
) (
   input  logic                           clk,
   input  logic                           _rst,
   input  logic                           ex_valid,
   output logic                           ex_ready,
   input  logic                           reg_w_en_in,
   input  logic [REG_FILE_ADDR_WIDTH-1:0] rd_addr_in,
   input  logic                           mem_r_en_in,
   input  logic                           mem_w_en_in,
   input  logic [1:0]                     mem_size_in,
   input  logic                           mem_uns_in,
   input  logic [XLEN-1:0]                mem_data_in,
   input  logic                           sel_mem_res,
   input  logic [XLEN-1:0]                res,
   output logic                           wb_valid,
   output logic                           reg_w_en_out,
   output logic [REG_FILE_ADDR_WIDTH-1:0] rd_addr_out,
   output logic [XLEN-1:0]                reg_data,
   me_stage_hs_if.master                  dmem,
`ifdef MISALIGN_TRAP_EN
   output logic                           misalign_o,
`endif
   output logic                           pb_reg_w_en,
   output logic [REG_FILE_ADDR_WIDTH-1:0] pb_rd_addr,
   output logic [XLEN-1:0]                pb_reg_data,
   output logic                           pb_busy
);

   localparam int NB = XLEN / 8;
   localparam int OB = $clog2(NB);
   localparam int RW = REG_FILE_ADDR_WIDTH;

   logic            v_q, v_d;
   logic            reg_w_en_q, reg_w_en_d;
   logic [RW-1:0]   rd_q, rd_d;
   logic            r_en_q, r_en_d;
   logic            w_en_q, w_en_d;
   logic [1:0]      size_q, size_d;
   logic            uns_q, uns_d;
   logic [XLEN-1:0] sdata_q, sdata_d;
   logic            sel_q, sel_d;
   logic [XLEN-1:0] res_q, res_d;
   me_state_e       st_q, st_d;

   logic            mis;
   logic [XLEN-1:0] addr_al;
   logic            mem_op, is_ld, req, done, capture;
   logic            rsp;
   logic [NB-1:0]   be;
   logic [XLEN-1:0] wdata, ld_data;

   always_comb begin
`ifdef MISALIGN_TRAP_EN
      addr_al = res_q;
      mis     = v_q & (r_en_q | w_en_q)
              & misaligned(res_q[2:0], size_q);
`else
      // silently align: clear address bits below the access size
      addr_al = res_q & ~XLEN'((8'd1 << size_q) - 8'd1);
      mis     = 1'b0;
`endif
      mem_op  = v_q & (r_en_q | w_en_q) & ~mis;
      is_ld   = r_en_q & ~w_en_q;
      req     = mem_op & (st_q == ST_IDLE);
      rsp     = v_q & (st_q == ST_WAIT_R) & dmem.dmem_rvalid;
      done    = (v_q & ~mem_op)
              | (req & w_en_q & dmem.dmem_gnt)
              | rsp;
      ex_ready = ~v_q | done;
      capture  = ex_valid & ex_ready;
   end

   always_comb begin
      st_d = st_q;
      unique case (1'b1)
         (st_q == ST_IDLE) & req & is_ld & dmem.dmem_gnt:
            st_d = ST_WAIT_R;
         rsp:
            st_d = ST_IDLE;
         default: ;
      endcase
   end

   always_comb begin
      v_d        = capture ? 1'b1 : (done ? 1'b0 : v_q);
      reg_w_en_d = reg_w_en_q;
      rd_d       = rd_q;
      r_en_d     = r_en_q;
      w_en_d     = w_en_q;
      size_d     = size_q;
      uns_d      = uns_q;
      sdata_d    = sdata_q;
      sel_d      = sel_q;
      res_d      = res_q;
      if (capture) begin
         reg_w_en_d = reg_w_en_in;
         rd_d       = rd_addr_in;
         r_en_d     = mem_r_en_in;
         w_en_d     = mem_w_en_in;
         size_d     = mem_size_in;
         uns_d      = mem_uns_in;
         sdata_d    = mem_data_in;
         sel_d      = sel_mem_res;
         res_d      = res;
      end
   end

   always_ff @(posedge clk or negedge _rst) begin
      if (!_rst) begin
         v_q        <= 1'b0;
         reg_w_en_q <= 1'b0;
         rd_q       <= '0;
         r_en_q     <= 1'b0;
         w_en_q     <= 1'b0;
         size_q     <= SZ_B;
         uns_q      <= 1'b0;
         sdata_q    <= '0;
         sel_q      <= 1'b0;
         res_q      <= '0;
         st_q       <= ST_IDLE;
      end else begin
         v_q        <= v_d;
         reg_w_en_q <= reg_w_en_d;
         rd_q       <= rd_d;
         r_en_q     <= r_en_d;
         w_en_q     <= w_en_d;
         size_q     <= size_d;
         uns_q      <= uns_d;
         sdata_q    <= sdata_d;
         sel_q      <= sel_d;
         res_q      <= res_d;
         st_q       <= st_d;
      end
   end

   me_lane_ctrl #(.XLEN(XLEN)) u_lane (
      .off     (addr_al[OB-1:0]),
      .size    (size_q),
      .uns     (uns_q),
      .st_data (sdata_q),
      .rdata   (dmem.dmem_rdata),
      .be      (be),
      .wdata   (wdata),
      .ld_data (ld_data)
   );

   assign dmem.dmem_req   = req;
   assign dmem.dmem_we    = mem_op & w_en_q;
   assign dmem.dmem_be    = mem_op ? be : '0;
   assign dmem.dmem_addr  = DATA_ADDR_WIDTH'(addr_al);
   assign dmem.dmem_wdata = wdata;

   assign wb_valid     = done;
   assign reg_w_en_out = done & reg_w_en_q & ~mis;
   assign rd_addr_out  = rd_q;
   assign reg_data     = sel_q ? ld_data : res_q;

`ifdef MISALIGN_TRAP_EN
   assign misalign_o = mis;
`endif

   assign pb_busy     = v_q & is_ld & ~mis & ~rsp;
   assign pb_reg_w_en = v_q & reg_w_en_q & ~mis & ~pb_busy;
   assign pb_rd_addr  = rd_q;
   assign pb_reg_data = reg_data;

endmodule

// File: tb/tb_me_stage_hs.sv
// Directed bench for me_stage_hs: a 32-bit and a 64-bit instance.
module tb_me_stage_hs;
   import me_stage_hs_pkg::*;

   logic clk = 1'b0;
   logic rst_n;
   logic ex_valid32, ex_valid64;
   logic reg_w_en_in, mem_r_en_in, mem_w_en_in;
   logic mem_uns_in, sel_mem_res;
   logic [4:0]  rd_addr_in;
   logic [1:0]  mem_size_in;
   logic [63:0] mem_data_in, res;

   logic ex_ready_a, wb_valid_a, reg_w_en_out_a;
   logic pb_reg_w_en_a, pb_busy_a;
   logic [4:0]  rd_addr_out_a, pb_rd_addr_a;
   logic [31:0] reg_data_a, pb_reg_data_a;
   logic ex_ready_b, wb_valid_b, reg_w_en_out_b;
   logic pb_reg_w_en_b, pb_busy_b;
   logic [4:0]  rd_addr_out_b, pb_rd_addr_b;
   logic [63:0] reg_data_b, pb_reg_data_b;
`ifdef MISALIGN_TRAP_EN
   logic mis_a, mis_b;
`endif

   int n_chk  = 0;
   int n_fail = 0;

   me_stage_hs_if #(.XLEN(32), .DAW(32)) bus_a ();
   me_stage_hs_if #(.XLEN(64), .DAW(32)) bus_b ();

   me_stage_hs #(.XLEN(32)) dut_a (
      .clk(clk), ._rst(rst_n),
      .ex_valid(ex_valid32), .ex_ready(ex_ready_a),
      .reg_w_en_in(reg_w_en_in), .rd_addr_in(rd_addr_in),
      .mem_r_en_in(mem_r_en_in), .mem_w_en_in(mem_w_en_in),
      .mem_size_in(mem_size_in), .mem_uns_in(mem_uns_in),
      .mem_data_in(mem_data_in[31:0]), .sel_mem_res(sel_mem_res),
      .res(res[31:0]),
      .wb_valid(wb_valid_a), .reg_w_en_out(reg_w_en_out_a),
      .rd_addr_out(rd_addr_out_a), .reg_data(reg_data_a),
      .dmem(bus_a.master),
`ifdef MISALIGN_TRAP_EN
      .misalign_o(mis_a),
`endif
      .pb_reg_w_en(pb_reg_w_en_a), .pb_rd_addr(pb_rd_addr_a),
      .pb_reg_data(pb_reg_data_a), .pb_busy(pb_busy_a)
   );

   me_stage_hs #(.XLEN(64)) dut_b (
      .clk(clk), ._rst(rst_n),
      .ex_valid(ex_valid64), .ex_ready(ex_ready_b),
      .reg_w_en_in(reg_w_en_in), .rd_addr_in(rd_addr_in),
      .mem_r_en_in(mem_r_en_in), .mem_w_en_in(mem_w_en_in),
      .mem_size_in(mem_size_in), .mem_uns_in(mem_uns_in),
      .mem_data_in(mem_data_in), .sel_mem_res(sel_mem_res),
      .res(res),
      .wb_valid(wb_valid_b), .reg_w_en_out(reg_w_en_out_b),
      .rd_addr_out(rd_addr_out_b), .reg_data(reg_data_b),
      .dmem(bus_b.master),
`ifdef MISALIGN_TRAP_EN
      .misalign_o(mis_b),
`endif
      .pb_reg_w_en(pb_reg_w_en_b), .pb_rd_addr(pb_rd_addr_b),
      .pb_reg_data(pb_reg_data_b), .pb_busy(pb_busy_b)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_ex(input logic we, input logic r, input logic w,
                         input logic [1:0] sz, input logic u,
                         input logic sel, input logic [4:0] rd,
                         input logic [63:0] rs, input logic [63:0] d);
      reg_w_en_in = we; mem_r_en_in = r; mem_w_en_in = w;
      mem_size_in = sz; mem_uns_in = u; sel_mem_res = sel;
      rd_addr_in = rd; res = rs; mem_data_in = d;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      ex_valid32 = 1'b0; ex_valid64 = 1'b0;
      set_ex(0, 0, 0, SZ_B, 0, 0, 5'd0, 64'd0, 64'd0);
      bus_a.dmem_gnt = 0; bus_a.dmem_rvalid = 0; bus_a.dmem_rdata = '0;
      bus_b.dmem_gnt = 0; bus_b.dmem_rvalid = 0; bus_b.dmem_rdata = '0;
      tick(); tick();
      n_chk++; if (ex_ready_a !== 1'b1) begin n_fail++; $display("FAIL rst_ex_ready: got %b want 1", ex_ready_a); end
      n_chk++; if (wb_valid_a !== 1'b0) begin n_fail++; $display("FAIL rst_wb_valid: got %b want 0", wb_valid_a); end
      n_chk++; if (bus_a.dmem_req !== 1'b0) begin n_fail++; $display("FAIL rst_req: got %b want 0", bus_a.dmem_req); end
      n_chk++; if (bus_a.dmem_be !== 4'h0) begin n_fail++; $display("FAIL rst_be: got %h want 0", bus_a.dmem_be); end
      n_chk++; if (reg_data_a !== 32'h0) begin n_fail++; $display("FAIL rst_reg_data: got %h want 0", reg_data_a); end
      n_chk++; if (pb_busy_a !== 1'b0 || pb_reg_w_en_a !== 1'b0) begin n_fail++; $display("FAIL rst_pb: got busy=%b wen=%b want 0 0", pb_busy_a, pb_reg_w_en_a); end
      rst_n = 1'b1;
   endtask

   task automatic test_alu();
      tick();
      set_ex(1, 0, 0, SZ_W, 0, 0, 5'd5, 64'h1234, 64'd0);
      ex_valid32 = 1; #1;
      n_chk++; if (ex_ready_a !== 1'b1) begin n_fail++; $display("FAIL alu_ready: got %b want 1", ex_ready_a); end
      tick();
      ex_valid32 = 0; #1;
      n_chk++; if (wb_valid_a !== 1'b1) begin n_fail++; $display("FAIL alu_wb_valid: got %b want 1", wb_valid_a); end
      n_chk++; if (reg_data_a !== 32'h1234) begin n_fail++; $display("FAIL alu_data: got %h want 00001234", reg_data_a); end
      n_chk++; if (rd_addr_out_a !== 5'd5 || reg_w_en_out_a !== 1'b1) begin n_fail++; $display("FAIL alu_rd: got rd=%0d wen=%b want 5 1", rd_addr_out_a, reg_w_en_out_a); end
      n_chk++; if (bus_a.dmem_req !== 1'b0) begin n_fail++; $display("FAIL alu_no_req: got %b want 0", bus_a.dmem_req); end
      tick(); #1;
      n_chk++; if (wb_valid_a !== 1'b0) begin n_fail++; $display("FAIL alu_wb_once: got %b want 0", wb_valid_a); end
   endtask

   task automatic test_lb();
      set_ex(1, 1, 0, SZ_B, 0, 1, 5'd6, 64'h103, 64'd0);
      ex_valid32 = 1;
      tick();
      ex_valid32 = 0; bus_a.dmem_gnt = 1; #1;
      n_chk++; if (bus_a.dmem_req !== 1'b1 || bus_a.dmem_we !== 1'b0) begin n_fail++; $display("FAIL lb_req: got req=%b we=%b want 1 0", bus_a.dmem_req, bus_a.dmem_we); end
      n_chk++; if (bus_a.dmem_be !== 4'b1000) begin n_fail++; $display("FAIL lb_be: got %b want 1000", bus_a.dmem_be); end
      n_chk++; if (bus_a.dmem_addr !== 32'h103) begin n_fail++; $display("FAIL lb_addr: got %h want 00000103", bus_a.dmem_addr); end
      n_chk++; if (ex_ready_a !== 1'b0 || pb_busy_a !== 1'b1) begin n_fail++; $display("FAIL lb_stall1: got ready=%b busy=%b want 0 1", ex_ready_a, pb_busy_a); end
      tick();
      bus_a.dmem_gnt = 0; #1;
      n_chk++; if (bus_a.dmem_req !== 1'b0 || wb_valid_a !== 1'b0) begin n_fail++; $display("FAIL lb_wait: got req=%b wb=%b want 0 0", bus_a.dmem_req, wb_valid_a); end
      n_chk++; if (ex_ready_a !== 1'b0 || pb_busy_a !== 1'b1) begin n_fail++; $display("FAIL lb_stall2: got ready=%b busy=%b want 0 1", ex_ready_a, pb_busy_a); end
      tick();
      bus_a.dmem_rvalid = 1; bus_a.dmem_rdata = 32'h8012_3456; #1;
      n_chk++; if (wb_valid_a !== 1'b1 || reg_w_en_out_a !== 1'b1) begin n_fail++; $display("FAIL lb_done: got wb=%b wen=%b want 1 1", wb_valid_a, reg_w_en_out_a); end
      n_chk++; if (reg_data_a !== 32'hFFFF_FF80) begin n_fail++; $display("FAIL lb_data: got %h want ffffff80", reg_data_a); end
      n_chk++; if (ex_ready_a !== 1'b1 || pb_busy_a !== 1'b0) begin n_fail++; $display("FAIL lb_release: got ready=%b busy=%b want 1 0", ex_ready_a, pb_busy_a); end
      tick(); #1;
      n_chk++; if (wb_valid_a !== 1'b0) begin n_fail++; $display("FAIL lb_idle_rvalid: got %b want 0", wb_valid_a); end
      bus_a.dmem_rvalid = 0;
   endtask

   task automatic test_sh();
      tick();
      set_ex(0, 0, 1, SZ_H, 0, 0, 5'd0, 64'h102, 64'hBEEF);
      ex_valid32 = 1;
      tick();
      ex_valid32 = 0; bus_a.dmem_gnt = 0;
      for (int i = 0; i < 3; i++) begin
         #1;
         n_chk++; if (bus_a.dmem_req !== 1'b1 || bus_a.dmem_we !== 1'b1) begin n_fail++; $display("FAIL sh_req%0d: got req=%b we=%b want 1 1", i, bus_a.dmem_req, bus_a.dmem_we); end
         n_chk++; if (bus_a.dmem_addr !== 32'h102 || bus_a.dmem_be !== 4'b1100) begin n_fail++; $display("FAIL sh_addr%0d: got %h/%b want 00000102/1100", i, bus_a.dmem_addr, bus_a.dmem_be); end
         n_chk++; if (bus_a.dmem_wdata !== 32'hBEEF_0000 || wb_valid_a !== 1'b0) begin n_fail++; $display("FAIL sh_wdata%0d: got %h wb=%b want beef0000 0", i, bus_a.dmem_wdata, wb_valid_a); end
         tick();
      end
      bus_a.dmem_gnt = 1; #1;
      n_chk++; if (wb_valid_a !== 1'b1 || reg_w_en_out_a !== 1'b0 || ex_ready_a !== 1'b1) begin n_fail++; $display("FAIL sh_retire: got wb=%b wen=%b rdy=%b want 1 0 1", wb_valid_a, reg_w_en_out_a, ex_ready_a); end
      tick();
      bus_a.dmem_gnt = 0; #1;
      n_chk++; if (bus_a.dmem_req !== 1'b0) begin n_fail++; $display("FAIL sh_req_drop: got %b want 0", bus_a.dmem_req); end
   endtask

   task automatic test_lwu64();
      set_ex(1, 1, 0, SZ_W, 1, 1, 5'd9, 64'h4, 64'd0);
      ex_valid64 = 1;
      tick();
      ex_valid64 = 0; bus_b.dmem_gnt = 1; #1;
      n_chk++; if (bus_b.dmem_be !== 8'hF0 || bus_b.dmem_req !== 1'b1) begin n_fail++; $display("FAIL lwu_be: got be=%h req=%b want f0 1", bus_b.dmem_be, bus_b.dmem_req); end
      tick();
      bus_b.dmem_gnt = 0; bus_b.dmem_rvalid = 1;
      bus_b.dmem_rdata = 64'hFFFF_FFFF_0000_0000; #1;
      n_chk++; if (wb_valid_b !== 1'b1) begin n_fail++; $display("FAIL lwu_wb: got %b want 1", wb_valid_b); end
      n_chk++; if (reg_data_b !== 64'h0000_0000_FFFF_FFFF) begin n_fail++; $display("FAIL lwu_data: got %h want 00000000ffffffff", reg_data_b); end
      tick();
      bus_b.dmem_rvalid = 0;
   endtask

   task automatic test_back_to_back();
      set_ex(1, 1, 0, SZ_W, 0, 1, 5'd7, 64'h200, 64'd0);
      ex_valid32 = 1;
      tick();
      set_ex(1, 0, 0, SZ_W, 0, 0, 5'd8, 64'h55, 64'd0);
      bus_a.dmem_gnt = 1; #1;
      n_chk++; if (pb_busy_a !== 1'b1 || pb_reg_w_en_a !== 1'b0) begin n_fail++; $display("FAIL b2b_busy1: got busy=%b wen=%b want 1 0", pb_busy_a, pb_reg_w_en_a); end
      n_chk++; if (pb_rd_addr_a !== 5'd7 || ex_ready_a !== 1'b0) begin n_fail++; $display("FAIL b2b_rd1: got rd=%0d rdy=%b want 7 0", pb_rd_addr_a, ex_ready_a); end
      tick();
      bus_a.dmem_gnt = 0; #1;
      n_chk++; if (pb_busy_a !== 1'b1 || ex_ready_a !== 1'b0) begin n_fail++; $display("FAIL b2b_busy2: got busy=%b rdy=%b want 1 0", pb_busy_a, ex_ready_a); end
      tick();
      bus_a.dmem_rvalid = 1; bus_a.dmem_rdata = 32'hCAFE_F00D; #1;
      n_chk++; if (wb_valid_a !== 1'b1 || reg_data_a !== 32'hCAFE_F00D) begin n_fail++; $display("FAIL b2b_ld: got wb=%b data=%h want 1 cafef00d", wb_valid_a, reg_data_a); end
      n_chk++; if (ex_ready_a !== 1'b1 || pb_reg_w_en_a !== 1'b1 || pb_reg_data_a !== 32'hCAFE_F00D) begin n_fail++; $display("FAIL b2b_fwd: got rdy=%b wen=%b data=%h want 1 1 cafef00d", ex_ready_a, pb_reg_w_en_a, pb_reg_data_a); end
      tick();
      bus_a.dmem_rvalid = 0; ex_valid32 = 0; #1;
      n_chk++; if (wb_valid_a !== 1'b1 || rd_addr_out_a !== 5'd8 || reg_data_a !== 32'h55) begin n_fail++; $display("FAIL b2b_alu: got wb=%b rd=%0d data=%h want 1 8 00000055", wb_valid_a, rd_addr_out_a, reg_data_a); end
      n_chk++; if (pb_busy_a !== 1'b0) begin n_fail++; $display("FAIL b2b_busy3: got %b want 0", pb_busy_a); end
      tick();
   endtask

   task automatic test_reset_mid();
      set_ex(0, 0, 1, SZ_W, 0, 0, 5'd0, 64'h400, 64'h1);
      ex_valid32 = 1;
      tick();
      ex_valid32 = 0; #1;
      n_chk++; if (bus_a.dmem_req !== 1'b1) begin n_fail++; $display("FAIL rmid_req: got %b want 1", bus_a.dmem_req); end
      rst_n = 0; #1;
      n_chk++; if (bus_a.dmem_req !== 1'b0) begin n_fail++; $display("FAIL rmid_req_drop: got %b want 0", bus_a.dmem_req); end
      tick();
      rst_n = 1;
      set_ex(1, 1, 0, SZ_W, 0, 1, 5'd3, 64'h500, 64'd0);
      ex_valid32 = 1;
      tick();
      ex_valid32 = 0; bus_a.dmem_gnt = 1;
      tick();
      bus_a.dmem_gnt = 0; #1;
      n_chk++; if (pb_busy_a !== 1'b1) begin n_fail++; $display("FAIL rmid_wait: got busy=%b want 1", pb_busy_a); end
      rst_n = 0; #1;
      n_chk++; if (bus_a.dmem_req !== 1'b0 || pb_busy_a !== 1'b0) begin n_fail++; $display("FAIL rmid_clear: got req=%b busy=%b want 0 0", bus_a.dmem_req, pb_busy_a); end
      bus_a.dmem_rvalid = 1; bus_a.dmem_rdata = 32'h1111_2222; #1;
      n_chk++; if (wb_valid_a !== 1'b0) begin n_fail++; $display("FAIL rmid_rvalid_rst: got %b want 0", wb_valid_a); end
      tick();
      rst_n = 1; #1;
      n_chk++; if (wb_valid_a !== 1'b0 || ex_ready_a !== 1'b1) begin n_fail++; $display("FAIL rmid_after: got wb=%b rdy=%b want 0 1", wb_valid_a, ex_ready_a); end
      bus_a.dmem_rvalid = 0;
      tick();
   endtask

   initial begin
      test_reset();
      test_alu();
      test_lb();
      test_sh();
      test_lwu64();
      test_back_to_back();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
